bsv_top: RTL and testbench

BSV_TOP -- requirements
Module: bsv_top

---
 rtl/bsv_pkg.sv | 23 ++
 rtl/bsv_top_rx.sv | 96 +++++++++
 rtl/bsv_top.sv | 156 +++++++++++++++
 tb/tb_bsv_top.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsv_pkg.sv
// Shared constants and state encodings for the UART multiply-accumulate block.
// Holds the bit-period default, clear command, accumulator width, RX/TX states.
package bsv_pkg;

    localparam int         CLKS_PER_BIT_DEF = 417;
    localparam logic [7:0] CLEAR_CMD        = 8'h80;
    localparam int         ACC_W            = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/bsv_top_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and start-bit glitch rejection.
// Ports: clk, rst_n, rxd in; data byte, valid pulse, frame_err pulse out.
module uart_rx
    import bsv_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Sync flops reset high so the first falling edge after reset starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
        endcase
    end

    assign data      = shift_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/bsv_top.sv
// UART signed 4x4 multiply-accumulate: RX byte -> MAC -> 1-entry hold -> TX.
// Ports: CLK, RST_N, serial_rxd in; serial_txd, red/green/blue LEDs out.
module bsv_top
    import bsv_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic serial_rxd,
    output logic serial_txd,
    output logic red,
    output logic green,
    output logic blue
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (CLK),
        .rst_n     (RST_N),
        .rxd       (serial_rxd),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ferr_q, ferr_d;
    logic             green_q, green_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             txd_q, txd_d;

    logic signed [7:0] op_hi, op_lo, prod;
    logic [ACC_W-1:0]  acc_sum;
    logic              tx_done, tx_load;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q       <= '0;
            ferr_q      <= 1'b0;
            green_q     <= 1'b1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_data_q   <= '0;
            txd_q       <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            ferr_q      <= ferr_d;
            green_q     <= green_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            txd_q       <= txd_d;
        end
    end

    always_comb begin
        op_hi   = {{4{rx_data[7]}}, rx_data[7:4]};
        op_lo   = {{4{rx_data[3]}}, rx_data[3:0]};
        prod    = op_hi * op_lo;
        acc_sum = acc_q + {{(ACC_W - 8){prod[7]}}, prod};

        acc_d       = acc_q;
        ferr_d      = ferr_q;
        green_d     = green_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + 1'b1;
        tx_bit_d    = tx_bit_q;
        tx_data_d   = tx_data_q;
        txd_d       = txd_q;

        tx_done = (tx_cnt_q == LAST);
        // Chaining straight from STOP keeps back-to-back frames gap-free.
        tx_load = hold_full_q &&
                  ((tx_state_q == TX_IDLE) ||
                   (tx_state_q == TX_STOP && tx_done));

        unique case (tx_state_q)
            TX_IDLE: tx_cnt_d = '0;
            TX_START: begin
                if (tx_done) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    txd_d      = tx_data_q[0];
                end
            end
            TX_DATA: begin
                if (tx_done) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        txd_d    = tx_data_q[tx_bit_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_done) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
        endcase

        if (tx_load) begin
            tx_state_d  = TX_START;
            tx_cnt_d    = '0;
            tx_data_d   = hold_q;
            txd_d       = 1'b0;
            hold_full_d = 1'b0;
        end

        // Written after the load so a same-cycle result refills the register.
        if (rx_valid) begin
            green_d     = ~green_q;
            hold_full_d = 1'b1;
            if (rx_data == CLEAR_CMD) begin
                acc_d  = '0;
                ferr_d = 1'b0;
                hold_d = 8'h00;
            end else begin
                acc_d  = acc_sum;
                hold_d = acc_sum[7:0];
            end
        end

        if (rx_ferr) ferr_d = 1'b1;
    end

    assign serial_txd = txd_q;
    assign red        = ~ferr_q;
    assign green      = green_q;
    assign blue       = (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_bsv_top.sv
// Directed scoreboard bench for bsv_top with 16 clocks per UART bit.
// Drives RX frames, decodes TX frames and compares against a queued model.
module tb_bsv_top;

    localparam int CPB = 16;

    logic clk, rst_n, serial_rxd;
    logic serial_txd, red, green, blue;

    bsv_top #(.CLKS_PER_BIT(CPB)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .serial_rxd (serial_rxd),
        .serial_txd (serial_txd),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] m_acc = '0;
    logic        m_green = 1'b1;
    logic        rst_hit = 1'b0;
    logic        bb_win = 1'b0;
    int          bb_rises = 0;
    logic [7:0]  got;
    logic [7:0]  want;
    logic        stopb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] b);
        int hi, lo;
        if (b == 8'h80) begin
            m_acc = '0;
            return 8'h00;
        end
        hi = b[7] ? int'(b[7:4]) - 16 : int'(b[7:4]);
        lo = b[3] ? int'(b[3:0]) - 16 : int'(b[3:0]);
        m_acc = m_acc + 16'(hi * lo);
        return m_acc[7:0];
    endfunction

    // Called only at a falling clock edge; returns at a falling clock edge.
    task automatic send(input logic [7:0] b, input logic stop_ok);
        serial_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        serial_rxd = 1'b1;
        if (stop_ok) begin
            exp_q.push_back(model(b));
            m_green = ~m_green;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || blue !== 1'b1) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 16'(t < 5000), 16'd1);
        repeat (4) @(negedge clk);
    endtask

    // TX frame decoder: samples at bit centres and pops the scoreboard.
    initial forever begin
        @(negedge serial_txd);
        if (rst_n === 1'b1) begin
            rst_hit = 1'b0;
            repeat (CPB / 2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 got[i] = serial_txd;
            end
            repeat (CPB) @(posedge clk);
            #1 stopb = serial_txd;
            if (!rst_hit) begin
                chk("tx_expected", 16'(exp_q.size() != 0), 16'd1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    chk("tx_byte", 16'(got), 16'(want));
                end
                chk("tx_stop", 16'(stopb), 16'd1);
            end
        end
    end

    initial forever begin
        @(negedge rst_n);
        rst_hit = 1'b1;
    end

    initial forever begin
        @(posedge blue);
        if (bb_win) bb_rises++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        serial_rxd = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_txd", 16'(serial_txd), 16'd1);
        chk("rst_red", 16'(red), 16'd1);
        chk("rst_green", 16'(green), 16'd1);
        chk("rst_blue", 16'(blue), 16'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h23, 1'b1);
        drain();
        chk("green_one", 16'(green), 16'(m_green));
        send(8'hF2, 1'b1);
        drain();
        chk("green_two", 16'(green), 16'd1);

        send(8'h80, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) send(8'h88, 1'b1);
        drain();
        send(8'h80, 1'b1);
        drain();

        send(8'h23, 1'b0);
        repeat (300) @(negedge clk);
        chk("ferr_red", 16'(red), 16'd0);
        chk("ferr_no_tx", 16'(blue), 16'd1);
        send(8'h11, 1'b1);
        drain();
        chk("ferr_red_sticky", 16'(red), 16'd0);

        serial_rxd = 1'b0;
        repeat (4) @(negedge clk);
        serial_rxd = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_tx", 16'(blue), 16'd1);
        chk("glitch_green", 16'(green), 16'(m_green));
        send(8'h23, 1'b1);
        drain();

        bb_rises = 0;
        fork
            begin
                send(8'h35, 1'b1);
                send(8'h7F, 1'b1);
                send(8'hC4, 1'b1);
            end
            begin
                int t = 0;
                while (blue !== 1'b0 && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                chk("bb_start", 16'(blue), 16'd0);
                bb_win = 1'b1;
            end
        join
        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("bb_timeout", 16'(t < 2000), 16'd1);
        end
        bb_win = 1'b0;
        chk("bb_blue_gap", 16'(bb_rises), 16'd0);
        drain();

        send(8'h80, 1'b1);
        drain();
        chk("clear_red", 16'(red), 16'd1);
        chk("green_model", 16'(green), 16'(m_green));

        send(8'h11, 1'b1);
        begin
            int t = 0;
            while (serial_txd !== 1'b0 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("mid_tx_seen", 16'(serial_txd), 16'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_txd", 16'(serial_txd), 16'd1);
        chk("async_blue", 16'(blue), 16'd1);
        chk("async_green", 16'(green), 16'd1);
        exp_q.delete();
        m_acc = '0;
        m_green = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);

        send(8'h23, 1'b1);
        drain();
        chk("post_rst_red", 16'(red), 16'd1);
        chk("post_rst_green", 16'(green), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
